// File: rtl/ysyx_24070014_mem_responder.sv
// Single-outstanding load/store responder over valid/ready channels, backed by a word-addressed SRAM.
// Optional macro YSYX_24070014_MEM_RANDOM_DELAY_EN adds 0-3 LFSR-driven extra wait cycles per transaction.
module ysyx_24070014_mem_responder #(
    parameter int unsigned         ADDR_LEN   = 32,
    parameter int unsigned         DATA_LEN   = 32,
    parameter int unsigned         DEPTH_LOG2 = 12,
    parameter logic [ADDR_LEN-1:0] BASE_ADDR  = ADDR_LEN'(32'h8000_0000),
    parameter int unsigned         LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wen,
    input  logic [ADDR_LEN-1:0]   req_addr,
    input  logic [DATA_LEN-1:0]   req_wdata,
    input  logic [DATA_LEN/8-1:0] req_wmask,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_LEN-1:0]   rsp_rdata,
    output logic                  rsp_err
);

    localparam int unsigned STRB_W  = DATA_LEN / 8;
    localparam int unsigned OFF_LSB = $clog2(STRB_W);
    localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W   = 5;
    localparam int unsigned AW1     = ADDR_LEN + 1;

    // One extra address bit so the upper bound cannot wrap when the array reaches the top of the space.
    localparam logic [AW1-1:0]      BASE_EXT   = {1'b0, BASE_ADDR};
    localparam logic [AW1-1:0]      LIMIT_EXT  = BASE_EXT + (AW1'(STRB_W) << DEPTH_LOG2);
    localparam logic [ADDR_LEN-1:0] ALIGN_MASK = ADDR_LEN'(STRB_W - 1);
    localparam logic [CNT_W-1:0]    CNT_BASE   = CNT_W'(LATENCY - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]            state;
    logic [1:0]            state_n;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_n;
    logic [CNT_W-1:0]      cnt_init;

    logic                  wen_q;
    logic [ADDR_LEN-1:0]   addr_q;
    logic [DATA_LEN-1:0]   wdata_q;
    logic [STRB_W-1:0]     wmask_q;

    logic                  accept_c;
    logic                  access_c;
    logic                  acc_wen;
    logic                  acc_err;
    logic [ADDR_LEN-1:0]   acc_addr;
    logic [ADDR_LEN-1:0]   acc_off;
    logic [DATA_LEN-1:0]   acc_wdata;
    logic [STRB_W-1:0]     acc_wmask;
    logic [DEPTH_LOG2-1:0] acc_idx;

    logic [DATA_LEN-1:0]   mem [DEPTH];

`ifdef YSYX_24070014_MEM_RANDOM_DELAY_EN
    logic [7:0] lfsr;

    // Fibonacci LFSR, taps 8,6,5,4; free-running from the reset seed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr <= 8'hA5;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign cnt_init = CNT_BASE + CNT_W'(lfsr[1:0]);
`else
    assign cnt_init = CNT_BASE;
`endif

    // Next-state, delay counter and access strobe.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        accept_c = (state == IDLE) && req_valid && reset;
        access_c = 1'b0;
        case (state)
            IDLE: begin
                if (accept_c) begin
                    cnt_n = cnt_init;
                    if (cnt_init == '0) begin
                        state_n  = RESP;
                        access_c = 1'b1;
                    end else begin
                        state_n = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_n  = RESP;
                    access_c = 1'b1;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // A zero-delay access executes on the acceptance edge, so it uses the live request.
    always_comb begin
        acc_wen   = (state == IDLE) ? req_wen   : wen_q;
        acc_addr  = (state == IDLE) ? req_addr  : addr_q;
        acc_wdata = (state == IDLE) ? req_wdata : wdata_q;
        acc_wmask = (state == IDLE) ? req_wmask : wmask_q;
        acc_off   = acc_addr - BASE_ADDR;
        acc_idx   = DEPTH_LOG2'(acc_off >> OFF_LSB);
        acc_err   = ({1'b0, acc_addr} < BASE_EXT) ||
                    ({1'b0, acc_addr} >= LIMIT_EXT) ||
                    ((acc_addr & ALIGN_MASK) != '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            req_ready <= (state_n == IDLE);
            rsp_valid <= (state_n == RESP);
        end
    end

    // Request capture and response payload; payload only changes on an access edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wen_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wmask_q   <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept_c) begin
                wen_q   <= req_wen;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                wmask_q <= req_wmask;
            end
            if (access_c) begin
                rsp_err   <= acc_err;
                rsp_rdata <= (!acc_wen && !acc_err) ? mem[acc_idx] : '0;
            end
        end
    end

    // Array is intentionally not reset.
    always_ff @(posedge clk) begin
        if (access_c && acc_wen && !acc_err) begin
            for (int unsigned b = 0; b < STRB_W; b++) begin
                if (acc_wmask[b]) begin
                    mem[acc_idx][b*8 +: 8] <= acc_wdata[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ysyx_24070014_mem_responder.sv
// Directed bench: one responder at LATENCY=1 and one at LATENCY=4, driven by handshake tasks.
module tb_ysyx_24070014_mem_responder;

    logic        clk;
    logic        reset     [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_wen   [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_wmask [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];

    int n_total = 0;
    int n_pass  = 0;

    ysyx_24070014_mem_responder #(.LATENCY(1)) u_dut_l1 (
        .clk       (clk),
        .reset     (reset[0]),
        .req_valid (req_valid[0]),
        .req_ready (req_ready[0]),
        .req_wen   (req_wen[0]),
        .req_addr  (req_addr[0]),
        .req_wdata (req_wdata[0]),
        .req_wmask (req_wmask[0]),
        .rsp_valid (rsp_valid[0]),
        .rsp_ready (rsp_ready[0]),
        .rsp_rdata (rsp_rdata[0]),
        .rsp_err   (rsp_err[0])
    );

    ysyx_24070014_mem_responder #(.LATENCY(4)) u_dut_l4 (
        .clk       (clk),
        .reset     (reset[1]),
        .req_valid (req_valid[1]),
        .req_ready (req_ready[1]),
        .req_wen   (req_wen[1]),
        .req_addr  (req_addr[1]),
        .req_wdata (req_wdata[1]),
        .req_wmask (req_wmask[1]),
        .rsp_valid (rsp_valid[1]),
        .rsp_ready (rsp_ready[1]),
        .rsp_rdata (rsp_rdata[1]),
        .rsp_err   (rsp_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // Present a request at a negedge and return just after its acceptance edge.
    task automatic send(input int i, input logic wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wmask);
        int waited = 0;
        @(negedge clk);
        while (!req_ready[i] && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        req_valid[i] = 1'b1;
        req_wen[i]   = wen;
        req_addr[i]  = addr;
        req_wdata[i] = wdata;
        req_wmask[i] = wmask;
        @(posedge clk);
        #1 req_valid[i] = 1'b0;
    endtask

    // Counts edges after acceptance until rsp_valid; returns at the negedge where it is seen.
    task automatic await_rsp(input int i, output int lat, output logic ready_seen);
        lat        = 0;
        ready_seen = 1'b0;
        @(negedge clk);
        while (!rsp_valid[i] && lat < 40) begin
            if (req_ready[i]) ready_seen = 1'b1;
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic txn(input int i, input string tag, input logic wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wmask, input int exp_lat,
                       input logic [31:0] exp_rdata, input logic exp_err);
        int   lat;
        logic rs;
        rsp_ready[i] = 1'b1;
        send(i, wen, addr, wdata, wmask);
        await_rsp(i, lat, rs);
        check({tag, ".lat"},   32'(lat), 32'(exp_lat));
        check({tag, ".err"},   32'(rsp_err[i]), 32'(exp_err));
        check({tag, ".rdata"}, rsp_rdata[i], exp_rdata);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        int   seen;
        logic rs;
        for (int i = 0; i < 2; i++) begin
            reset[i]     = 1'b0;
            req_valid[i] = 1'b0;
            req_wen[i]   = 1'b0;
            req_addr[i]  = '0;
            req_wdata[i] = '0;
            req_wmask[i] = '0;
            rsp_ready[i] = 1'b1;
        end

        // Reset held with a request pending: nothing may be accepted.
        req_valid[0] = 1'b1;
        req_wen[0]   = 1'b1;
        req_addr[0]  = 32'h8000_0000;
        req_wdata[0] = 32'hFFFF_FFFF;
        req_wmask[0] = 4'hF;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst.ready", 32'(req_ready[0]), 32'd1);
            check("rst.valid", 32'(rsp_valid[0]), 32'd0);
            check("rst.rdata", rsp_rdata[0], 32'd0);
            check("rst.err",   32'(rsp_err[0]), 32'd0);
        end
        check("rst.l4", {29'd0, req_ready[1], rsp_valid[1], rsp_err[1]}, 32'b100);
        req_valid[0] = 1'b0;
        reset[0]     = 1'b1;
        reset[1]     = 1'b1;
        @(negedge clk);
        check("post_rst.l1", {30'd0, req_ready[0], rsp_valid[0]}, 32'b10);
        check("post_rst.l4", {30'd0, req_ready[1], rsp_valid[1]}, 32'b10);

        // LATENCY=1: store/load, byte mask, faults, top-of-array boundary.
        txn(0, "st_dead", 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF,    0, 32'h0,         1'b0);
        txn(0, "ld_dead", 1'b0, 32'h8000_0010, 32'h0,         4'h0,    0, 32'hDEAD_BEEF, 1'b0);
        txn(0, "st_mask", 1'b1, 32'h8000_0010, 32'h1122_3344, 4'b0101, 0, 32'h0,         1'b0);
        txn(0, "ld_mask", 1'b0, 32'h8000_0010, 32'h0,         4'h0,    0, 32'hDE22_BE44, 1'b0);
        txn(0, "st_base", 1'b1, 32'h8000_0000, 32'h0102_0304, 4'hF,    0, 32'h0,         1'b0);
        txn(0, "ld_low",  1'b0, 32'h7FFF_FFFC, 32'h0,         4'h0,    0, 32'h0,         1'b1);
        txn(0, "ld_mis",  1'b0, 32'h8000_0012, 32'h0,         4'h0,    0, 32'h0,         1'b1);
        txn(0, "st_oob",  1'b1, 32'h8000_4000, 32'hFFFF_FFFF, 4'hF,    0, 32'h0,         1'b1);
        txn(0, "st_last", 1'b1, 32'h8000_3FFC, 32'hA5A5_5A5A, 4'hF,    0, 32'h0,         1'b0);
        txn(0, "ld_last", 1'b0, 32'h8000_3FFC, 32'h0,         4'h0,    0, 32'hA5A5_5A5A, 1'b0);
        txn(0, "ld_base", 1'b0, 32'h8000_0000, 32'h0,         4'h0,    0, 32'h0102_0304, 1'b0);

        // LATENCY=4 with response backpressure.
        txn(1, "st40", 1'b1, 32'h8000_0040, 32'h0BAD_C0DE, 4'hF, 4, 32'h0, 1'b0);
        rsp_ready[1] = 1'b0;
        send(1, 1'b0, 32'h8000_0040, 32'h0, 4'h0);
        await_rsp(1, lat, rs);
        check("bp.lat",   32'(lat), 32'd4);
        check("bp.ready", 32'(rs), 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp.hold.ctl",   {29'd0, rsp_valid[1], req_ready[1], rsp_err[1]}, 32'b100);
            check("bp.hold.rdata", rsp_rdata[1], 32'h0BAD_C0DE);
        end
        rsp_ready[1] = 1'b1;
        @(posedge clk);
        #1;
        check("bp.done", {30'd0, req_ready[1], rsp_valid[1]}, 32'b10);

        // Reset during WAIT must drop the store.
        txn(1, "st20", 1'b1, 32'h8000_0020, 32'h1111_1111, 4'hF, 4, 32'h0, 1'b0);
        send(1, 1'b1, 32'h8000_0020, 32'hCAFE_F00D, 4'hF);
        @(posedge clk);
        @(posedge clk);
        #2 reset[1] = 1'b0;
        @(negedge clk);
        check("mw.in_rst", {30'd0, req_ready[1], rsp_valid[1]}, 32'b10);
        reset[1] = 1'b1;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (rsp_valid[1]) seen++;
        end
        check("mw.no_rsp", 32'(seen), 32'd0);
        txn(1, "ld20", 1'b0, 32'h8000_0020, 32'h0, 4'h0, 4, 32'h1111_1111, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
